// File: rtl/kbd_ctl.sv
// PS/2 keyboard receiver and arrow-key decoder: turns scan-code frames into a
// held-key bitmap (up/down/left/right) and flags malformed or stalled frames.
module kbd_ctl #(
  parameter int unsigned TIMEOUT = 65000
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] key,
  output logic       frame_err
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic       {RX_IDLE, RX_RECV} rx_state_e;
  typedef enum logic [1:0] {D_IDLE, D_EXT, D_BRK, D_EXT_BRK} dec_state_e;

  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic data_meta_q, data_sync_q;
  logic fall;

  rx_state_e     rx_state_q, rx_state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [8:0]    shift_q, shift_d;
  logic [CW-1:0] idle_cnt_q, idle_cnt_d;
  logic [7:0]    byte_q, byte_d;
  logic          byte_valid_q, byte_valid_d;
  logic          frame_err_q, frame_err_d;

  dec_state_e    dec_q, dec_d;
  logic [3:0]    key_q, key_d;
  logic [3:0]    arrow_mask;

  // Falling edge of the synchronized PS/2 clock; data is sampled alongside it.
  assign fall = clk_prev_q & ~clk_sync_q;

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    rx_state_d   = rx_state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    idle_cnt_d   = idle_cnt_q;
    byte_d       = byte_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        idle_cnt_d = '0;
        if (fall && !data_sync_q) begin
          rx_state_d = RX_RECV;
          bit_cnt_d  = '0;
        end
      end
      RX_RECV: begin
        if (fall) begin
          idle_cnt_d = '0;
          if (bit_cnt_q == 4'd9) begin
            rx_state_d = RX_IDLE;
            if ((^shift_q) && data_sync_q) begin
              byte_valid_d = 1'b1;
              byte_d       = shift_q[7:0];
            end else begin
              frame_err_d = 1'b1;
            end
          end else begin
            // Bits arrive LSB first, so shift in at the top.
            shift_d   = {data_sync_q, shift_q[8:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else if (idle_cnt_q == CW'(TIMEOUT - 1)) begin
          rx_state_d  = RX_IDLE;
          frame_err_d = 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q + CW'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    case (byte_q)
      8'h75:   arrow_mask = 4'b0001;
      8'h72:   arrow_mask = 4'b0010;
      8'h6B:   arrow_mask = 4'b0100;
      8'h74:   arrow_mask = 4'b1000;
      default: arrow_mask = 4'b0000;
    endcase
  end

  always_comb begin
    dec_d = dec_q;
    key_d = key_q;
    if (frame_err_q) begin
      dec_d = D_IDLE;
    end else if (byte_valid_q) begin
      case (dec_q)
        D_IDLE: begin
          if (byte_q == 8'hE0)                         dec_d = D_EXT;
          else if (byte_q == 8'hF0)                    dec_d = D_BRK;
          else if (byte_q == 8'h00 || byte_q == 8'hFF) key_d = 4'b0000;
        end
        D_EXT: begin
          dec_d = (byte_q == 8'hF0) ? D_EXT_BRK : D_IDLE;
          key_d = key_q | arrow_mask;
        end
        D_EXT_BRK: begin
          dec_d = D_IDLE;
          key_d = key_q & ~arrow_mask;
        end
        default: dec_d = D_IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      clk_meta_q   <= 1'b0;
      clk_sync_q   <= 1'b0;
      clk_prev_q   <= 1'b0;
      data_meta_q  <= 1'b0;
      data_sync_q  <= 1'b0;
      rx_state_q   <= RX_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      idle_cnt_q   <= '0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      dec_q        <= D_IDLE;
      key_q        <= '0;
    end else begin
      clk_meta_q   <= ps2_clk;
      clk_sync_q   <= clk_meta_q;
      clk_prev_q   <= clk_sync_q;
      data_meta_q  <= ps2_data;
      data_sync_q  <= data_meta_q;
      rx_state_q   <= rx_state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      idle_cnt_q   <= idle_cnt_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      dec_q        <= dec_d;
      key_q        <= key_d;
    end
  end

  assign key       = key_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_kbd_ctl.sv
// Scoreboard bench for kbd_ctl: the driver bit-bangs PS/2 frames and queues the
// events a keyboard model predicts; a monitor pops them as the DUT reports them.
module tb_kbd_ctl;

  localparam int TIMEOUT = 200;
  localparam int HALF    = 8;

  logic       pclk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic [3:0] key;
  logic       frame_err;

  always #5 pclk = ~pclk;

  kbd_ctl #(.TIMEOUT(TIMEOUT)) dut (
    .pclk      (pclk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .key       (key),
    .frame_err (frame_err)
  );

  typedef struct packed {
    logic       is_err;
    logic [3:0] key;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] pend[$];
  logic [3:0] model_key = 4'h0;
  logic [3:0] last_key;
  logic       mon_en = 1'b0;
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_ev(input logic is_err, input logic [3:0] k);
    ev_t e;
    e.is_err = is_err;
    e.key    = k;
    exp_q.push_back(e);
  endtask

  // Keyboard model: prefix bytes are remembered in a queue, arrows edit a bitmap.
  function automatic logic [3:0] arrow_of(input logic [7:0] b);
    case (b)
      8'h75:   return 4'b0001;
      8'h72:   return 4'b0010;
      8'h6B:   return 4'b0100;
      8'h74:   return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic model_byte(input logic [7:0] b);
    logic [3:0] old;
    old = model_key;
    if (pend.size() == 0) begin
      if (b == 8'hE0 || b == 8'hF0)      pend.push_back(b);
      else if (b == 8'h00 || b == 8'hFF) model_key = 4'h0;
    end else if (pend.size() == 1 && pend[0] == 8'hE0) begin
      pend.delete();
      if (b == 8'hF0) begin
        pend.push_back(8'hE0);
        pend.push_back(8'hF0);
      end else begin
        model_key = model_key | arrow_of(b);
      end
    end else if (pend.size() == 2) begin
      pend.delete();
      model_key = model_key & ~arrow_of(b);
    end else begin
      pend.delete();
    end
    if (model_key != old) push_ev(1'b0, model_key);
  endtask

  task automatic model_err();
    pend.delete();
    push_ev(1'b1, 4'h0);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic ps2_bit(input logic v);
    ps2_data = v;
    tick(HALF);
    ps2_clk = 1'b0;
    tick(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad);
    logic [10:0] bits;
    logic        par;
    par  = (~^b) ^ bad;
    bits = {1'b1, par, b, 1'b0};
    if (bad) model_err();
    else     model_byte(b);
    for (int i = 0; i < 11; i++) ps2_bit(bits[i]);
    tick(3 * HALF);
  endtask

  task automatic send_partial(input int n);
    ps2_bit(1'b0);
    for (int i = 0; i < n; i++) ps2_bit(1'($urandom_range(0, 1)));
    ps2_data = 1'b1;
  endtask

  task automatic expect_ev(input logic is_err, input logic [3:0] k);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected event: got err=%b key=%b, expected none (t=%0t)", is_err, k, $time);
    end else begin
      e = exp_q.pop_front();
      check("event type (1=frame_err)", 8'(is_err), 8'(e.is_err));
      if (!is_err) check("key value", 8'(k), 8'(e.key));
    end
  endtask

  always @(negedge pclk) begin
    if (mon_en) begin
      if (frame_err === 1'b1) expect_ev(1'b1, 4'h0);
      if (key !== last_key)   expect_ev(1'b0, key);
      last_key = key;
    end
  end

  logic [7:0] pool [10] = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74,
                            8'h00, 8'hFF, 8'h1C, 8'hE0};

  initial begin
    rst      = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    tick(4);
    rst = 1'b0;
    tick(2);
    check("reset key", 8'(key), 8'h00);
    check("reset frame_err", 8'(frame_err), 8'h00);
    last_key = key;
    mon_en   = 1'b1;

    // Press and release up.
    send_frame(8'hE0, 0); send_frame(8'h75, 0);
    send_frame(8'hE0, 0); send_frame(8'hF0, 0); send_frame(8'h75, 0);

    // Right, up, release right.
    send_frame(8'hE0, 0); send_frame(8'h74, 0);
    send_frame(8'hE0, 0); send_frame(8'h75, 0);
    send_frame(8'hE0, 0); send_frame(8'hF0, 0); send_frame(8'h74, 0);

    // Parity error, then a good frame pair bringing key to 0011.
    send_frame(8'h75, 1);
    send_frame(8'hE0, 0); send_frame(8'h72, 0);
    check("key 0011 before overrun", 8'(key), 8'h03);

    // Overrun clears; a numpad 75 does nothing.
    send_frame(8'hFF, 0);
    send_frame(8'h75, 0);

    // Stalled frame times out, then left.
    send_partial(3);
    model_err();
    tick(TIMEOUT + 60);
    send_frame(8'hE0, 0); send_frame(8'h6B, 0);
    check("key 0100 after timeout", 8'(key), 8'h04);

    // Reset in the middle of a frame that follows an E0 prefix.
    send_frame(8'hE0, 0);
    send_partial(5);
    pend.delete();
    if (model_key != 4'h0) push_ev(1'b0, 4'h0);
    model_key = 4'h0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(10);
    check("key after mid-frame reset", 8'(key), 8'h00);
    send_frame(8'hE0, 0); send_frame(8'h72, 0);

    // Random traffic from a biased byte pool with occasional bad parity.
    for (int i = 0; i < 60; i++) begin
      logic [7:0] b;
      b = pool[$urandom_range(0, 9)];
      if ($urandom_range(0, 9) == 0) b = 8'($urandom);
      send_frame(b, $urandom_range(0, 7) == 0);
    end

    tick(50);
    check("scoreboard drained", 8'(exp_q.size()), 8'h00);
    check("final key", 8'(key), 8'(model_key));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/kbd_ctl.md
KBD_CTL -- requirements
Module: kbd_ctl

Interface
REQ-001 Parameter: TIMEOUT, default 65000, pclk cycles without a PS/2 clock falling edge before a partial frame is abandoned (about 1 ms at 65 MHz).
REQ-002 Port: pclk  input  1  system pixel clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: ps2_clk  input  1  PS/2 keyboard clock, asynchronous to pclk.
REQ-005 Port: ps2_data  input  1  PS/2 keyboard data, asynchronous to pclk.
REQ-006 Port: key  output  4  registered held-key bitmap: bit0 up, bit1 down, bit2 left, bit3 right; feeds the car controller key input.
REQ-007 Port: frame_err  output  1  registered, one-cycle pulse per discarded frame.

Function
REQ-008 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer before any use.
REQ-009 A falling edge SHALL be detected in the cycle where synchronized ps2_clk was 1 last cycle and is 0 now; ps2_data is sampled in that same cycle.
REQ-010 Receiver FSM SHALL have states RX_IDLE and RX_RECV.
REQ-011 In RX_IDLE, an edge with data=0 (start bit) SHALL enter RX_RECV with bit count 0; an edge with data=1 SHALL be ignored.
REQ-012 In RX_RECV, the receiver SHALL shift in 8 data bits LSB first, then 1 parity bit, then 1 stop bit, 10 edges total after the start bit.
REQ-013 At the stop-bit edge, the frame SHALL be accepted only if data bits plus parity have odd parity and stop=1; the byte_valid strobe is then asserted for one cycle in the next cycle.
REQ-014 On a parity or stop failure, the byte SHALL be dropped, frame_err pulses for one cycle in the next cycle, and the FSM returns to RX_IDLE.
REQ-015 In RX_RECV, an idle counter SHALL reset on every edge; reaching TIMEOUT without an edge SHALL abandon the frame, pulse frame_err, and return to RX_IDLE.
REQ-016 Decoder FSM SHALL have states D_IDLE, D_EXT (after E0), D_BRK (after F0), D_EXT_BRK (after E0 F0), and SHALL advance only on byte_valid.
REQ-017 D_IDLE transitions: E0 goes to D_EXT; F0 goes to D_BRK; 00 or FF (overrun) clears key to 0000 and stays; any other byte stays, key unchanged.
REQ-018 D_EXT transitions: 75/72/6B/74 set key bit 0/1/2/3 respectively and go to D_IDLE; F0 goes to D_EXT_BRK; any other byte goes to D_IDLE.
REQ-019 D_EXT_BRK transitions: 75/72/6B/74 clear key bit 0/1/2/3 and go to D_IDLE; any other byte goes to D_IDLE.
REQ-020 D_BRK: any byte goes to D_IDLE with key unchanged. Non-extended 75/72/6B/74 are numpad keys and never affect key.
REQ-021 Typematic repeat of a held key SHALL leave key unchanged; several bits may be set at once, and key reports the raw bitmap with no priority encoding.
REQ-022 key SHALL update on the rising edge following the byte_valid cycle: two pclk edges after the cycle in which the stop-bit edge is detected.
REQ-023 A frame_err SHALL force the decoder to D_IDLE; key is retained.

Reset
REQ-024 When rst=1 at a rising edge: key=0000, frame_err=0, both FSMs idle, and bit counter, shift register, idle counter and synchronizers cleared.
REQ-025 A reset mid-frame or mid-prefix SHALL discard the partial data; no byte_valid or frame_err follows from it.

Verification
REQ-026 Send frames E0, 75 (valid parity) -> key=0001 two cycles after the stop edge of 75; then E0, F0, 75 -> key=0000.
REQ-027 Press right (E0 74), then up (E0 75), then release right (E0 F0 74) -> key sequence 1000, 1001, 0001.
REQ-028 Send byte 75 with inverted parity -> frame_err is high for exactly 1 cycle, key unchanged, next valid frame decoded correctly.
REQ-029 Send start bit plus 3 data bits, then hold ps2_clk high for TIMEOUT cycles -> frame_err pulses once, receiver returns to idle, following E0 6B gives key=0100.
REQ-030 With key=0011, send FF -> key=0000; send non-extended 75 -> key stays 0000.
REQ-031 Assert rst during bit 5 of a frame following an E0 -> key=0000, no frame_err; a fresh E0 72 then gives key=0010.
